// File: rtl/snn_pkg.sv
// Shared types and defaults for the spike-count decoder.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        ARGMAX = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int SNN_N_OUT = 8;
    localparam int SNN_CNT_W = 8;
    localparam int SNN_WIN_W = 16;

    // All-ones value at which a default-width spike counter stops counting.
    localparam logic [SNN_CNT_W-1:0] SNN_CNT_MAX = '1;

endpackage

// File: rtl/snn_sat_counter.sv
// Saturating up-counter with synchronous clear and enable; clear has priority.
module snn_sat_counter
    import snn_pkg::*;
#(
    parameter int W = SNN_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/snn_spike_decoder.sv
// Counts output spikes per neuron over a window and reports the arg-max neuron.
// Optional tie output enabled by defining SNN_SPIKE_DECODER_TIE_FLAG_EN.
module snn_spike_decoder
    import snn_pkg::*;
#(
    parameter  int N_OUT = SNN_N_OUT,
    parameter  int CNT_W = SNN_CNT_W,
    parameter  int WIN_W = SNN_WIN_W,
    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    input  logic [N_OUT-1:0] spk_in,
    input  logic             spk_valid,
    output logic [IDX_W-1:0] class_id,
    output logic [CNT_W-1:0] class_count,
    output logic             class_valid,
    input  logic             class_ready,
    output logic             busy,
`ifdef SNN_SPIKE_DECODER_TIE_FLAG_EN
    output logic             tie,
`endif
    output state_e           state_dbg
);

    // Handshake: a result transfers on the rising edge where class_valid and
    // class_ready are both high; class_valid never drops before that edge and
    // class_id/class_count hold while it is high.

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    state_e           state;
    logic [WIN_W-1:0] steps;
    logic [IDX_W-1:0] scan_idx;
    logic             commit;
    logic [IDX_W-1:0] best_id;
    logic [CNT_W-1:0] best_cnt;
    logic [CNT_W-1:0] cnt [N_OUT];
    logic [CNT_W-1:0] scan_cnt;
    logic             cnt_clr;
    logic             accum_step;
`ifdef SNN_SPIKE_DECODER_TIE_FLAG_EN
    logic             tie_run;
`endif

    assign state_dbg  = state;
    assign cnt_clr    = (state == IDLE) && start;
    assign accum_step = (state == ACCUM) && spk_valid;
    assign scan_cnt   = cnt[scan_idx];

    for (genvar i = 0; i < N_OUT; i++) begin : g_cnt
        snn_sat_counter #(
            .W(CNT_W)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (cnt_clr),
            .en    (accum_step && spk_in[i]),
            .count (cnt[i])
        );
    end

    // The scan visits one index per cycle; one extra commit cycle copies the
    // winner into the output registers so they only change on entry to DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            steps       <= '0;
            scan_idx    <= '0;
            commit      <= 1'b0;
            best_id     <= '0;
            best_cnt    <= '0;
            class_id    <= '0;
            class_count <= '0;
            class_valid <= 1'b0;
            busy        <= 1'b0;
`ifdef SNN_SPIKE_DECODER_TIE_FLAG_EN
            tie_run     <= 1'b0;
            tie         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACCUM;
                        busy  <= 1'b1;
                        steps <= (window_len == '0) ? WIN_W'(1) : window_len;
                    end
                end
                ACCUM: begin
                    if (spk_valid) begin
                        steps <= steps - WIN_W'(1);
                        if (steps == WIN_W'(1)) begin
                            state    <= ARGMAX;
                            scan_idx <= '0;
                            commit   <= 1'b0;
                        end
                    end
                end
                ARGMAX: begin
                    if (commit) begin
                        state       <= DONE;
                        class_id    <= best_id;
                        class_count <= best_cnt;
                        class_valid <= 1'b1;
`ifdef SNN_SPIKE_DECODER_TIE_FLAG_EN
                        tie         <= tie_run;
`endif
                    end else begin
                        // Strict compare keeps the lowest index on a tie.
                        if ((scan_idx == '0) || (scan_cnt > best_cnt)) begin
                            best_id  <= scan_idx;
                            best_cnt <= scan_cnt;
`ifdef SNN_SPIKE_DECODER_TIE_FLAG_EN
                            tie_run  <= 1'b0;
`endif
                        end else if (scan_cnt == best_cnt) begin
`ifdef SNN_SPIKE_DECODER_TIE_FLAG_EN
                            tie_run  <= 1'b1;
`endif
                        end
                        if (scan_idx == LAST_IDX) begin
                            commit <= 1'b1;
                        end else begin
                            scan_idx <= scan_idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (class_ready) begin
                        state       <= IDLE;
                        class_valid <= 1'b0;
                        busy        <= 1'b0;
`ifdef SNN_SPIKE_DECODER_TIE_FLAG_EN
                        tie         <= 1'b0;
`endif
                    end
                end
                default: begin
                    state       <= IDLE;
                    class_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_spike_decoder.sv
// Directed bench for snn_spike_decoder with hand-computed expectations.
module tb_snn_spike_decoder;
    import snn_pkg::*;

    localparam int N_OUT = 8;
    localparam int CNT_W = 8;
    localparam int WIN_W = 16;
    localparam int IDX_W = 3;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIN_W-1:0] window_len;
    logic [N_OUT-1:0] spk_in;
    logic             spk_valid;
    logic [IDX_W-1:0] class_id;
    logic [CNT_W-1:0] class_count;
    logic             class_valid;
    logic             class_ready;
    logic             busy;
`ifdef SNN_SPIKE_DECODER_TIE_FLAG_EN
    logic             tie;
`endif
    state_e           state_dbg;

    int errors = 0;
    int checks = 0;
    int cyc;

    snn_spike_decoder #(
        .N_OUT(N_OUT),
        .CNT_W(CNT_W),
        .WIN_W(WIN_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .window_len  (window_len),
        .spk_in      (spk_in),
        .spk_valid   (spk_valid),
        .class_id    (class_id),
        .class_count (class_count),
        .class_valid (class_valid),
        .class_ready (class_ready),
        .busy        (busy),
`ifdef SNN_SPIKE_DECODER_TIE_FLAG_EN
        .tie         (tie),
`endif
        .state_dbg   (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_window(input logic [WIN_W-1:0] len);
        start      = 1'b1;
        window_len = len;
        tick();
        start      = 1'b0;
        window_len = '0;
    endtask

    task automatic spike(input logic [N_OUT-1:0] pat);
        spk_valid = 1'b1;
        spk_in    = pat;
        tick();
        spk_valid = 1'b0;
        spk_in    = '0;
    endtask

    task automatic gap(input logic [N_OUT-1:0] junk);
        spk_valid = 1'b0;
        spk_in    = junk;
        tick();
        spk_in    = '0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (class_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        class_ready = 1'b1;
        tick();
        class_ready = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        window_len  = '0;
        spk_in      = '0;
        spk_valid   = 1'b0;
        class_ready = 1'b0;
        repeat (3) tick();
        chk("rst_id", 32'(class_id), 0);
        chk("rst_count", 32'(class_count), 0);
        chk("rst_valid", 32'(class_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_state", 32'(state_dbg), 32'(IDLE));
`ifdef SNN_SPIKE_DECODER_TIE_FLAG_EN
        chk("rst_tie", 32'(tie), 0);
`endif
        reset = 1'b0;
        tick();

        // Basic window: four steps of 8'h05 -> neurons 0 and 2 at 4, lowest wins
        start_window(16'd4);
        chk("basic_busy", 32'(busy), 1);
        chk("basic_state", 32'(state_dbg), 32'(ACCUM));
        repeat (4) spike(8'h05);
        chk("basic_argmax", 32'(state_dbg), 32'(ARGMAX));
        wait_valid(cyc);
        chk("basic_latency", 32'(cyc), 9);
        chk("basic_id", 32'(class_id), 0);
        chk("basic_count", 32'(class_count), 4);
`ifdef SNN_SPIKE_DECODER_TIE_FLAG_EN
        chk("basic_tie", 32'(tie), 1);
`endif
        handshake();
        chk("basic_ack_valid", 32'(class_valid), 0);
        chk("basic_ack_busy", 32'(busy), 0);

        // Tie between neurons 2 and 5 at 3; neurons 0 and 1 at 1
        start_window(16'd3);
        spike(8'h27);
        spike(8'h24);
        spike(8'h24);
        wait_valid(cyc);
        chk("tie_latency", 32'(cyc), 9);
        chk("tie_id", 32'(class_id), 2);
        chk("tie_count", 32'(class_count), 3);
`ifdef SNN_SPIKE_DECODER_TIE_FLAG_EN
        chk("tie_flag", 32'(tie), 1);
`endif
        handshake();

        // Saturation: 300 steps on neuron 7 clamps at 255
        start_window(16'd300);
        spk_valid = 1'b1;
        spk_in    = 8'h80;
        repeat (300) tick();
        spk_valid = 1'b0;
        spk_in    = '0;
        wait_valid(cyc);
        chk("sat_latency", 32'(cyc), 9);
        chk("sat_id", 32'(class_id), 7);
        chk("sat_count", 32'(class_count), 255);
`ifdef SNN_SPIKE_DECODER_TIE_FLAG_EN
        chk("sat_tie", 32'(tie), 0);
`endif
        handshake();

        // Gaps with junk spikes and an early class_ready; then backpressure
        start_window(16'd3);
        spike(8'h10);
        class_ready = 1'b1;
        gap(8'hFF);
        class_ready = 1'b0;
        gap(8'hFF);
        spike(8'h18);
        chk("gap_still_accum", 32'(state_dbg), 32'(ACCUM));
        gap(8'hFF);
        spike(8'h08);
        wait_valid(cyc);
        chk("gap_latency", 32'(cyc), 9);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", 32'(class_valid), 1);
            chk("hold_id", 32'(class_id), 3);
            chk("hold_count", 32'(class_count), 2);
        end
`ifdef SNN_SPIKE_DECODER_TIE_FLAG_EN
        chk("gap_tie", 32'(tie), 1);
`endif
        handshake();
        chk("gap_ack_state", 32'(state_dbg), 32'(IDLE));
        chk("gap_ack_valid", 32'(class_valid), 0);

        // Ignored start in ACCUM and DONE, spikes discarded in DONE
        start_window(16'd2);
        spike(8'h01);
        start      = 1'b1;
        window_len = 16'd5;
        gap(8'h00);
        start      = 1'b0;
        window_len = '0;
        chk("ign_accum_state", 32'(state_dbg), 32'(ACCUM));
        spike(8'h01);
        wait_valid(cyc);
        chk("ign_latency", 32'(cyc), 9);
        start     = 1'b1;
        spk_valid = 1'b1;
        spk_in    = 8'hFF;
        tick();
        start     = 1'b0;
        spk_valid = 1'b0;
        spk_in    = '0;
        chk("ign_done_state", 32'(state_dbg), 32'(DONE));
        chk("ign_done_id", 32'(class_id), 0);
        chk("ign_done_count", 32'(class_count), 2);
        start       = 1'b1;
        window_len  = 16'd4;
        class_ready = 1'b1;
        tick();
        start       = 1'b0;
        window_len  = '0;
        class_ready = 1'b0;
        chk("ign_hs_state", 32'(state_dbg), 32'(IDLE));
        chk("ign_hs_busy", 32'(busy), 0);

        // Asynchronous reset mid-window, then a zero-length window counts one step
        start_window(16'd5);
        spike(8'hFF);
        spike(8'hFF);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_valid", 32'(class_valid), 0);
        chk("arst_state", 32'(state_dbg), 32'(IDLE));
        #1 reset = 1'b0;
        tick();
        chk("arst_no_result", 32'(class_valid), 0);
        start_window(16'd0);
        spike(8'h40);
        chk("zero_len_argmax", 32'(state_dbg), 32'(ARGMAX));
        wait_valid(cyc);
        chk("zero_len_latency", 32'(cyc), 9);
        chk("zero_len_id", 32'(class_id), 6);
        chk("zero_len_count", 32'(class_count), 1);
`ifdef SNN_SPIKE_DECODER_TIE_FLAG_EN
        chk("zero_len_tie", 32'(tie), 0);
`endif
        handshake();
        chk("final_state", 32'(state_dbg), 32'(IDLE));

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
